// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - mechanical switch contact bounce emulator
//
// Purpose: turns a clean commanded level into a contact-like waveform.
// On a level change: first contact, a pseudo-random bouncing phase, a
// guaranteed-stable hold phase, then a one-cycle done pulse.
//
// Ports:
//   clk       system clock, rising-edge active
//   reset     asynchronous, active-high reset
//   level_in  clean commanded switch level (synchronous to clk)
//   sw_out    emulated contact output with bounce (registered)
//   busy      high while a transition sequence is in progress
//   done      one-cycle pulse when a sequence completes (registered)

module bounce_gen #(
  parameter int          TICK_M       = 50_000,
  parameter int          BOUNCE_TICKS = 40,
  parameter int          HOLD_TICKS   = 80,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic sw_out,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(TICK_M);
  localparam int BW = $clog2(BOUNCE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  generate
    if (SEED == 16'h0000) begin : g_bad_seed
      $error("bounce_gen: SEED must be non-zero, an all-zero LFSR never advances");
    end
    if (TICK_M < 2) begin : g_bad_tick
      $error("bounce_gen: TICK_M must be 2 or more");
    end
    if (BOUNCE_TICKS < 1 || HOLD_TICKS < 1) begin : g_bad_ticks
      $error("bounce_gen: BOUNCE_TICKS and HOLD_TICKS must be 1 or more");
    end
  endgenerate

  typedef enum logic [1:0] {
    STABLE = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        state;
  logic          tgt;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [HW-1:0] hcnt;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic          tick;

  assign tick      = (cnt == CW'(TICK_M - 1));
  // Galois right-shift form, taps 16,14,13,11.
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign busy      = (state != STABLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= STABLE;
      tgt    <= 1'b0;
      sw_out <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      bcnt   <= '0;
      hcnt   <= '0;
      lfsr   <= SEED;
    end else begin
      done <= 1'b0;
      cnt  <= tick ? '0 : cnt + 1'b1;

      case (state)
        STABLE: begin
          sw_out <= tgt;
          if (level_in != tgt) begin
            // First contact lands immediately; the tick phase restarts so
            // the sequence length is independent of where the counter was.
            tgt    <= level_in;
            sw_out <= level_in;
            bcnt   <= BW'(BOUNCE_TICKS);
            cnt    <= '0;
            state  <= BOUNCE;
          end
        end

        BOUNCE: begin
          if (tick) begin
            if (bcnt > BW'(1)) begin
              lfsr   <= lfsr_next;
              sw_out <= lfsr_next[0];
              bcnt   <= bcnt - 1'b1;
            end else begin
              sw_out <= tgt;
              hcnt   <= HW'(HOLD_TICKS);
              state  <= SETTLE;
            end
          end
        end

        SETTLE: begin
          sw_out <= tgt;
          if (tick) begin
            hcnt <= hcnt - 1'b1;
            if (hcnt == HW'(1)) begin
              state <= STABLE;
              done  <= 1'b1;
            end
          end
        end

        default: state <= STABLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// tb/tb_bounce_gen.sv - self-checking bench for bounce_gen

module tb_bounce_gen;

  localparam int TICK_M = 4;
  localparam int BT     = 5;
  localparam int HT     = 3;
  localparam int TOTAL  = (BT + HT) * TICK_M;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic level_in = 1'b0;
  logic sw_out, busy, done;

  int errors = 0;
  int checks = 0;

  bounce_gen #(
    .TICK_M(TICK_M), .BOUNCE_TICKS(BT), .HOLD_TICKS(HT), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .level_in(level_in),
    .sw_out(sw_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a sequence is described by the number of cycles k
  // elapsed since its entry edge; the output follows from which tick
  // window k falls into.
  logic        m_busy, m_tgt, m_sw, m_done;
  int          m_k;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tgt = 0; m_sw = 0; m_done = 0; m_k = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic lvl);
    if (!m_busy) begin
      m_done = 0;
      if (lvl != m_tgt) begin
        m_tgt = lvl; m_busy = 1; m_k = 0; m_sw = lvl;
      end
    end else begin
      m_k++;
      if (m_k == TOTAL) begin
        m_busy = 0; m_done = 1; m_sw = m_tgt;
      end else begin
        m_done = 0;
        if (m_k % TICK_M == 0) begin
          if (m_k / TICK_M < BT) begin
            m_lfsr = lfsr_adv(m_lfsr);
            m_sw = m_lfsr[0];
          end else begin
            m_sw = m_tgt;
          end
        end
      end
    end
  endtask

  // Drive at negedge, clock one rising edge, sample at the following negedge.
  task automatic step(input logic lvl);
    level_in = lvl;
    @(posedge clk);
    if (!reset) model_step(lvl);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    level_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    level_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (sw_out !== 1'b0) begin errors++; $display("FAIL reset_sw_out got=%b exp=0", sw_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr got=%h exp=ace1", dut.lfsr); end
    checks++; if (dut.tgt !== 1'b0) begin errors++; $display("FAIL reset_tgt got=%b exp=0", dut.tgt); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic exp_sw, exp_busy, exp_done;
    int dones = 0;
    do_reset();
    repeat (3) step(1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      exp_sw   = (i < 4) || (i >= 20);
      exp_busy = (i < 32);
      exp_done = (i == 32);
      if (done === 1'b1) dones++;
      checks++; if (sw_out !== exp_sw) begin errors++; $display("FAIL basic_sw_out i=%0d got=%b exp=%b", i, sw_out, exp_sw); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL basic_busy i=%0d got=%b exp=%b", i, busy, exp_busy); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL basic_done i=%0d got=%b exp=%b", i, done, exp_done); end
      if (i == 19) begin
        checks++; if (dut.lfsr !== 16'h1C4E) begin errors++; $display("FAIL basic_lfsr got=%h exp=1c4e", dut.lfsr); end
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_idle();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step(1'b0);
      if (sw_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_outputs nonzero_cycles=%0d exp=0", bad); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL idle_lfsr got=%h exp=ace1", dut.lfsr); end
  endtask

  task automatic test_ignore();
    logic lvl;
    int dones = 0;
    do_reset();
    step(1'b0);
    for (int i = 0; i < 46; i++) begin
      lvl = !((i >= 5 && i < 10) || (i >= 22 && i < 25));
      step(lvl);
      if (done === 1'b1) dones++;
      checks++;
      if (sw_out !== m_sw || busy !== m_busy || done !== m_done) begin
        errors++;
        $display("FAIL ignore_model i=%0d got sw=%b busy=%b done=%b exp sw=%b busy=%b done=%b",
                 i, sw_out, busy, done, m_sw, m_busy, m_done);
      end
    end
    checks++; if (dut.tgt !== 1'b1) begin errors++; $display("FAIL ignore_tgt got=%b exp=1", dut.tgt); end
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b0);
    for (int i = 0; i < 51; i++) begin
      step((i < 25) ? 1'b1 : 1'b0);
      checks++;
      if (sw_out !== m_sw || busy !== m_busy || done !== m_done) begin
        errors++;
        $display("FAIL b2b_model i=%0d got sw=%b busy=%b done=%b exp sw=%b busy=%b done=%b",
                 i, sw_out, busy, done, m_sw, m_busy, m_done);
      end
      if (i == 32) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
      end
      if (i == 33) begin
        checks++; if (busy !== 1'b1 || sw_out !== 1'b0) begin errors++; $display("FAIL b2b_reentry got busy=%b sw=%b exp busy=1 sw=0", busy, sw_out); end
      end
      if (i == 37) begin
        checks++; if (dut.lfsr !== 16'h0E27 || sw_out !== 1'b1) begin errors++; $display("FAIL b2b_lfsr_continue got lfsr=%h sw=%b exp lfsr=0e27 sw=1", dut.lfsr, sw_out); end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    step(1'b0);
    level_in = 1'b1;
    #2 level_in = 1'b0;
    step(1'b0);
    step(1'b0);
    checks++; if (busy !== 1'b0 || sw_out !== 1'b0 || dut.tgt !== 1'b0) begin errors++; $display("FAIL glitch got busy=%b sw=%b tgt=%b exp all 0", busy, sw_out, dut.tgt); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    do_reset();
    step(1'b0);
    repeat (11) step(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (sw_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_outputs got sw=%b busy=%b done=%b exp 0", sw_out, busy, done); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL midreset_lfsr got=%h exp=ace1", dut.lfsr); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midreset_done got=%0d pulses exp=0", dones); end
    level_in = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_release_high();
    reset = 1'b1;
    level_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b1);
    checks++; if (busy !== 1'b1 || sw_out !== 1'b1 || dut.tgt !== 1'b1) begin errors++; $display("FAIL release_high got busy=%b sw=%b tgt=%b exp all 1", busy, sw_out, dut.tgt); end
    repeat (40) step(1'b1);
    checks++; if (busy !== 1'b0 || sw_out !== 1'b1) begin errors++; $display("FAIL release_high_end got busy=%b sw=%b exp busy=0 sw=1", busy, sw_out); end
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int fails = 0;
    do_reset();
    for (int i = 0; i < 10000 && fails < 20; i++) begin
      if ($urandom_range(23, 0) == 0) lvl = ~lvl;
      step(lvl);
      checks++;
      if (sw_out !== m_sw || busy !== m_busy || done !== m_done) begin
        errors++;
        fails++;
        $display("FAIL random_model cyc=%0d got sw=%b busy=%b done=%b exp sw=%b busy=%b done=%b",
                 i, sw_out, busy, done, m_sw, m_busy, m_done);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_idle();
    test_ignore();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_release_high();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter TICK_M, default 50_000: clk cycles per bounce tick; legal range is 2 or more.
REQ-002 Parameter BOUNCE_TICKS, default 40: ticks spent in the bouncing phase; legal range is 1 or more.
REQ-003 Parameter HOLD_TICKS, default 80: ticks of guaranteed-stable output after bouncing; legal range is 1 or more.
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset value; zero is illegal and the design shall flag it with an elaboration-time assertion.
REQ-005 clk  input  1  system clock, rising-edge active.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 level_in  input  1  clean commanded switch level, synchronous to clk.
REQ-008 sw_out  output  1  emulated mechanical-contact signal with bounce, registered.
REQ-009 busy  output  1  high while a transition sequence is in progress.
REQ-010 done  output  1  single-cycle pulse when a sequence completes.

Function
REQ-011 The tick counter shall be free-running, $clog2(TICK_M) bits wide, counting 0..TICK_M-1 and wrapping to 0.
REQ-012 The tick counter shall be forced to 0 on the clock edge that enters BOUNCE.
REQ-013 tick shall be combinational, high when count == TICK_M-1, so tick-driven actions occur every TICK_M cycles.
REQ-014 The LFSR shall be 16-bit Galois, right-shifting: next = (lfsr >> 1) XOR (lfsr[0] ? 16'hB400 : 16'h0000).
REQ-015 The LFSR shall advance only on tick while in BOUNCE, shall hold otherwise, and shall not be reloaded between sequences.
REQ-016 The FSM shall have three states: STABLE, BOUNCE, SETTLE.
REQ-017 A registered target level tgt shall record the level being driven.
REQ-018 STABLE, level_in == tgt: sw_out = tgt; the FSM remains in STABLE.
REQ-019 STABLE, level_in != tgt: next edge sets tgt <= level_in, sw_out <= level_in (first contact), state <= BOUNCE, bounce counter <= BOUNCE_TICKS.
REQ-020 BOUNCE, on tick with bounce counter > 1: LFSR advances, sw_out <= new lfsr[0], bounce counter decrements.
REQ-021 BOUNCE, on tick with bounce counter == 1: sw_out <= tgt, hold counter <= HOLD_TICKS, state <= SETTLE.
REQ-022 BOUNCE_TICKS == 1 shall produce no random samples: sw_out holds tgt from entry onward.
REQ-023 SETTLE: sw_out shall remain tgt; on each tick the hold counter decrements.
REQ-024 SETTLE, on tick with hold counter == 1: state <= STABLE and done <= 1 for exactly one cycle.
REQ-025 Total sequence length shall be (BOUNCE_TICKS + HOLD_TICKS) * TICK_M cycles from the BOUNCE entry edge to the done edge.
REQ-026 busy shall be derived from the state register: 1 in BOUNCE or SETTLE, 0 in STABLE.
REQ-027 level_in changes during BOUNCE or SETTLE shall be ignored; tgt is not updated.
REQ-028 If level_in != tgt in the cycle done is high, a new sequence shall start on the next edge, back-to-back.
REQ-029 A level_in pulse that returns to tgt while in STABLE before being sampled shall produce no sequence.

Reset
REQ-030 Reset asserted shall immediately force: state = STABLE, tgt = 0, sw_out = 0, busy = 0, done = 0, tick counter = 0, bounce and hold counters = 0, lfsr = SEED.
REQ-031 Reset asserted mid-sequence shall abort the sequence, with no done pulse.
REQ-032 If level_in = 1 at reset release, a sequence shall start on the first clock edge after release.

Verification
Parameters for all scenarios: TICK_M=4, BOUNCE_TICKS=5, HOLD_TICKS=3, SEED=16'hACE1.
REQ-033 Reset then level_in 0->1 -> starting at the entry edge, sw_out = 1 for 4 cycles, then 0 for 16 cycles (LFSR states E270, 7138, 389C, 1C4E), then 1 steady. busy is high for 32 cycles and done pulses once, 32 edges after entry.
REQ-034 level_in held at 0 from reset -> sw_out, busy and done stay 0 for 1000 cycles, and the LFSR does not advance.
REQ-035 level_in toggled 1->0->1 during BOUNCE -> sequence unaffected, tgt = 1; no second sequence, because level_in == tgt at done.
REQ-036 level_in 0->1, then 1->0 during SETTLE -> done pulses, next edge enters BOUNCE toward 0, and the LFSR continues from 1C4E.
REQ-037 Reset asserted 10 cycles into BOUNCE -> all outputs are 0 immediately and lfsr = ACE1; no done pulse.
REQ-038 Reference-model scoreboard with random level_in over 10,000 cycles -> sw_out, busy and done match the model cycle-exactly.
